// File: rtl/sub_shift_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sub_shift_stage : AES SubBytes (one column/cycle) then ShiftRows |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+

module sub_shift_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table is written entry 0 first, so entry x sits at bit offset 8*(255-x) = 8*~x.
  assign out_byte = c_sbox[{~in_byte, 3'b000} +: 8];
endmodule

module sub_shift_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);
  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_sub  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   w_next_state;
  logic [1:0]   r_cnt;
  logic [127:0] r_buf;
  logic [31:0]  w_col;
  logic [31:0]  w_col_sub;
  logic [127:0] w_shifted;
  logic         w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (in_valid) w_next_state = c_sub;
      c_sub:   if (r_cnt == 2'd3) w_next_state = c_done;
      c_done:  if (out_ready) w_next_state = in_valid ? c_sub : c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_state = '0;
    if (rst_n)
      in_ready = (r_state == c_idle) || ((r_state == c_done) && out_ready);
    if (r_state == c_done) begin
      out_valid = 1'b1;
      out_state = w_shifted;
    end
  end

  assign w_accept = in_valid & in_ready;
  assign w_col    = r_buf[32*r_cnt +: 32];

  generate
    for (genvar b = 0; b < 4; b++) begin : g_sbox
      sub_shift_sbox u_sbox (
        .in_byte  (w_col[8*b +: 8]),
        .out_byte (w_col_sub[8*b +: 8])
      );
    end
  endgenerate

  // Row r of the output is row r of the buffer rotated left by r columns.
  generate
    for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
        assign w_shifted[8*(4*c+r) +: 8] = r_buf[8*(4*((c+r)%4)+r) +: 8];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_buf <= in_state;
      r_cnt <= 2'd0;
    end else if (r_state == c_sub) begin
      r_buf[32*r_cnt +: 32] <= w_col_sub;
      r_cnt                 <= r_cnt + 2'd1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sub_shift_stage.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_sub_shift_stage : randomized + directed bench, GF(2^8) model  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_sub_shift_stage;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_state;

  int checks = 0;
  int errors = 0;
  int d_acc = 0;
  int d_hs = 0;

  logic [7:0]   sbox_ref [256];
  bit           m_have = 1'b0;
  int           m_age = 0;
  logic [127:0] m_data = '0;

  localparam logic [127:0] c_vec_in  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
  localparam logic [127:0] c_vec_out = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;

  always #5 clk = ~clk;

  sub_shift_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_out(input logic [127:0] s);
    logic [7:0]   sb [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) sb[i] = sbox_ref[s[8*i +: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = sb[4*((c+r)%4)+r];
    return o;
  endfunction

  function automatic bit exp_valid();
    return m_have && (m_age == 4);
  endfunction

  function automatic bit exp_ready();
    return rst_n && (!m_have || (exp_valid() && out_ready));
  endfunction

  function automatic logic [127:0] exp_state();
    return exp_valid() ? m_data : 128'h0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock edge: observe DUT handshakes and advance the latency model.
  task automatic tick();
    bit acc, hs;
    acc = in_valid && exp_ready();
    hs  = exp_valid() && out_ready;
    if (in_valid && in_ready === 1'b1) d_acc++;
    if (out_valid === 1'b1 && out_ready) d_hs++;
    @(posedge clk);
    if (hs) m_have = 1'b0;
    if (acc) begin
      m_have = 1'b1;
      m_age  = 0;
      m_data = ref_out(in_state);
    end else if (m_have && m_age < 4) begin
      m_age++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_state = c_vec_in; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    if (out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state got %h exp 0", out_state); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    in_valid = 1'b0; rst_n = 1'b1; m_have = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    tick();
  endtask

  task automatic test_known(input logic [127:0] vin, input logic [127:0] vexp, input string name);
    int lat;
    out_ready = 1'b1; in_valid = 1'b1; in_state = vin;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept_ready got %b exp 1", name, in_ready); end
    tick();
    in_valid = 1'b0; in_state = rand128();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
    checks += 3;
    if (lat != 4) begin errors++; $display("FAIL %s_latency got %0d exp 4", name, lat); end
    if (out_state !== vexp) begin errors++; $display("FAIL %s_data got %h exp %h", name, out_state, vexp); end
    if (out_state !== exp_state()) begin errors++; $display("FAIL %s_model got %h exp %h", name, out_state, exp_state()); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_after_handoff got %b exp 0", name, out_valid); end
  endtask

  task automatic test_stall();
    int h0;
    out_ready = 1'b0; in_valid = 1'b1; in_state = c_vec_in;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'($urandom_range(0, 1)); in_state = rand128();
      #1;
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b exp 1", k, out_valid); end
      if (out_state !== c_vec_out) begin errors++; $display("FAIL stall_data cyc %0d got %h exp %h", k, out_state, c_vec_out); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b exp 0", k, in_ready); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; h0 = d_hs;
    repeat (6) tick();
    checks += 2;
    if (d_hs - h0 != 1) begin errors++; $display("FAIL stall_release_handshakes got %0d exp 1", d_hs - h0); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_idle_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int first, second;
    first = -1; second = -1;
    out_ready = 1'b1; in_valid = 1'b1; in_state = c_vec_in;
    tick();
    in_state = 128'h0;
    for (int k = 0; k <= 14; k++) begin
      if (out_valid === 1'b1) begin
        if (first < 0) begin
          first = k;
          checks += 2;
          if (out_state !== c_vec_out) begin errors++; $display("FAIL b2b_first_data got %h exp %h", out_state, c_vec_out); end
          if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_handoff_ready got %b exp 1", in_ready); end
        end else if (second < 0) begin
          second = k;
          checks++;
          if (out_state !== {16{8'h63}}) begin errors++; $display("FAIL b2b_second_data got %h exp %h", out_state, {16{8'h63}}); end
        end
      end
      tick();
      if (k == first) in_valid = 1'b0;
    end
    checks += 2;
    if (first != 4) begin errors++; $display("FAIL b2b_first_cycle got %0d exp 4", first); end
    if (second - first != 5) begin errors++; $display("FAIL b2b_spacing got %0d exp 5", second - first); end
  endtask

  task automatic test_reset_mid();
    // Pulse during SUB with cnt=2.
    out_ready = 1'b1; in_valid = 1'b1; in_state = c_vec_in;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_sub_valid got %b exp 0", out_valid); end
    if (out_state !== 128'h0) begin errors++; $display("FAIL rst_sub_data got %h exp 0", out_state); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_sub_ready got %b exp 0", in_ready); end
    #1 rst_n = 1'b1; m_have = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_sub_ghost cyc %0d got %b exp 0", k, out_valid); end
    end
    // Pulse while stalled in DONE.
    out_ready = 1'b0; in_valid = 1'b1; in_state = c_vec_in;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_done_valid got %b exp 0", out_valid); end
    if (out_state !== 128'h0) begin errors++; $display("FAIL rst_done_data got %h exp 0", out_state); end
    #1 rst_n = 1'b1; m_have = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_done_ghost cyc %0d got %b exp 0", k, out_valid); end
    end
  endtask

  task automatic test_random();
    int a0, h0, cyc;
    a0 = d_acc; h0 = d_hs; cyc = 0;
    while ((d_acc - a0) < 1000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_state  = rand128();
      #1;
      checks += 3;
      if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, in_ready, exp_ready()); end
      if (out_valid !== exp_valid()) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", cyc, out_valid, exp_valid()); end
      if (out_state !== exp_state()) begin errors++; $display("FAIL rand_data cyc %0d got %h exp %h", cyc, out_state, exp_state()); end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    checks += 2;
    if ((d_acc - a0) < 1000) begin errors++; $display("FAIL rand_block_budget got %0d exp 1000", d_acc - a0); end
    if ((d_hs - h0) != (d_acc - a0)) begin errors++; $display("FAIL rand_handshakes got %0d exp %0d", d_hs - h0, d_acc - a0); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_known(c_vec_in, c_vec_out, "fips_round1");
    test_known(128'h0, {16{8'h63}}, "zeros");
    test_known({16{8'h53}}, {16{8'hed}}, "all53");
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_known(c_vec_in, c_vec_out, "after_reset");
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sub_shift_stage.md
SUB_SHIFT_STAGE -- requirements
Module: sub_shift_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge), rst_n (asynchronous, active-low); no other clocks or resets.
REQ-002 The block SHALL have no parameters; width is fixed at 128 bits.
REQ-003 The ports SHALL be as follows:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_state holds a block for SubBytes.
- in_ready  output  1  block can accept in_state this cycle.
- in_state  input  128  round state; byte i = in_state[8i+7:8i]; column c = bytes 4c..4c+3; row = i mod 4.
- out_valid  output  1  out_state holds a finished block.
- out_ready  input  1  downstream (MixColumns/round register) accepts out_state.
- out_state  output  128  ShiftRows(SubBytes(in_state)), same byte ordering; feeds mix_columns in_state directly.

Function
REQ-004 The block SHALL implement an FSM with states IDLE, SUB and DONE.
REQ-005 The block SHALL accept an input only on a rising edge with in_valid=1 and in_ready=1.
REQ-006 On accept, the block SHALL load in_state into a 128-bit buffer, clear a 2-bit column counter to 0 and enter SUB.
REQ-007 In SUB, each edge SHALL replace buffer column cnt (4 bytes) with S-box(byte) using exactly 4 S-box instances, then increment cnt.
REQ-008 The edge on which cnt=3 SHALL enter DONE; the counter wraps to 0.
REQ-009 The S-box SHALL be the FIPS-197 forward S-box (e.g. 0x00->0x63, 0x53->0xED, 0xFF->0x16).
REQ-010 In DONE, out_valid SHALL be 1 and out_state SHALL equal the combinational ShiftRows of the buffer: out byte 4c+r = buffer byte 4((c+r) mod 4)+r.
REQ-011 Outside DONE, out_valid SHALL be 0 and out_state SHALL equal 128'h0.
REQ-012 out_valid and out_state SHALL stay stable in DONE until out_ready=1; out_ready SHALL be ignored outside DONE.
REQ-013 in_ready SHALL be (state==IDLE) OR (state==DONE AND out_ready), gated to 0 while rst_n=0.
REQ-014 On DONE with out_ready=1 and in_valid=1, the same edge SHALL hand off the output and accept the new block (enter SUB, cnt=0); with in_valid=0 it SHALL enter IDLE.
REQ-015 Latency SHALL be 4 edges from the accept edge to out_valid=1.
REQ-016 Sustained throughput SHALL be one block per 5 cycles when downstream is always ready.
REQ-017 in_state and in_valid SHALL be ignored in SUB and while DONE is stalled; the buffer changes only on accept or on SUB edges.
REQ-018 There SHALL be no combinational path from in_state or in_valid to out_state or out_valid.

Reset
REQ-019 While rst_n=0, independent of clk, the block SHALL force state=IDLE, cnt=0, buffer=0, out_valid=0, out_state=0 and in_ready=0.
REQ-020 On the first cycle after rst_n deasserts, in_ready SHALL be 1.
REQ-021 Reset asserted during SUB or DONE SHALL discard the block in flight with no output handshake afterwards.

Verification
REQ-022 FIPS-197 App.B round 1: bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08, out_ready=1 -> out_valid 4 edges after accept; out bytes 0..15 = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
REQ-023 in_state=128'h0 -> out_state=all bytes 0x63; in_state=all bytes 0x53 -> all bytes 0xED.
REQ-024 out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, out_state stable, in_ready=0; changes to in_state are ignored; release -> exactly one handshake.
REQ-025 Back-to-back: in_valid=1 continuously with two vectors (REQ-022, then zeros) and out_ready=1 -> second accepted on first's handoff edge; outputs appear 5 cycles apart, in order.
REQ-026 rst_n pulsed low mid-SUB (cnt=2) between clock edges -> outputs zero immediately; no out_valid until a new accept; the next block (REQ-022 vector) produces the correct result.
REQ-027 Random stimulus -> out_state matches the reference model for ShiftRows(SubBytes(in_state)); out_valid/out_ready handshakes equal accepts (≥1000 blocks, random stalls).
